// File: rtl/dili_pointwise_mul_stage.sv
// Two-stage pointwise multiplier for NTT-domain coefficients: S1 captures (a, b, idx), S2 holds
// the full signed product for the Montgomery reduction stage. Handshakes are valid/ready.
module dili_pointwise_mul_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned Q     = 8380417,
  parameter int unsigned N     = 256,
  parameter int unsigned IDX_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic signed [WIDTH-1:0]   a_i,
  input  logic signed [WIDTH-1:0]   b_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic signed [2*WIDTH-1:0] prod_o,
  output logic [IDX_W-1:0]          idx_o,
  output logic                      last_o
);

  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(N - 1);

  // The modulus must fit a signed coefficient and the index must cover every coefficient.
  if (longint'(Q) >= (longint'(1) << (WIDTH - 1))) begin : g_q_check
    $error("Q does not fit in a signed WIDTH-bit coefficient");
  end
  if (IDX_W != $clog2(N)) begin : g_idx_check
    $error("IDX_W must equal clog2(N)");
  end

  logic                      s1_valid_q, s2_valid_q;
  logic signed [WIDTH-1:0]   s1_a_q, s1_b_q;
  logic [IDX_W-1:0]          s1_idx_q, s2_idx_q;
  logic signed [2*WIDTH-1:0] s2_prod_q;
  logic                      s2_last_q;
  logic [IDX_W-1:0]          cnt_q, cnt_d;

  logic                      s1_en, s2_en, in_xfer;
  logic signed [2*WIDTH-1:0] a_ext, b_ext, prod;

  always_comb begin
    s2_en   = !s2_valid_q || ready_i;
    s1_en   = !s1_valid_q || s2_en;
    ready_o = s1_en && !clear_i;
    in_xfer = valid_i && ready_o;
    cnt_d   = (cnt_q == IdxLast) ? '0 : cnt_q + 1'b1;
  end

  // Sign-extend explicitly so the product is exact over the full 2*WIDTH range.
  always_comb begin
    a_ext = {{WIDTH{s1_a_q[WIDTH-1]}}, s1_a_q};
    b_ext = {{WIDTH{s1_b_q[WIDTH-1]}}, s1_b_q};
    prod  = a_ext * b_ext;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else if (clear_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (s1_en)   s1_valid_q <= in_xfer;
      if (s2_en)   s2_valid_q <= s1_valid_q;
      if (in_xfer) cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_xfer) begin
      s1_a_q   <= a_i;
      s1_b_q   <= b_i;
      s1_idx_q <= cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_prod_q <= '0;
      s2_idx_q  <= '0;
      s2_last_q <= 1'b0;
    end else if (s2_en && s1_valid_q && !clear_i) begin
      s2_prod_q <= prod;
      s2_idx_q  <= s1_idx_q;
      s2_last_q <= (s1_idx_q == IdxLast);
    end
  end

  assign valid_o = s2_valid_q;
  assign prod_o  = s2_prod_q;
  assign idx_o   = s2_idx_q;
  assign last_o  = s2_last_q && s2_valid_q;

endmodule
